// File: rtl/long_inst_wb_arb.sv
// Round-robin writeback/commit arbiter for long-latency units sharing one regfile write port.
// Optional define LONG_WB_BYPASS_EN lets an idle port commit a fresh grant in the same cycle.
module long_inst_wb_arb #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*5-1:0]          req_rd_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id_i,
    input  logic                          wb_port_busy_i,
    output logic                          reg_we_o,
    output logic [4:0]                    reg_waddr_o,
    output logic [DATA_WIDTH-1:0]         reg_wdata_o,
    output logic                          commit_valid_o,
    output logic [ID_WIDTH-1:0]           commit_id_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   L_NUM  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] L_LAST = PTR_W'(NUM_REQ - 1);

    logic                  r_out_valid;
    logic [4:0]            r_out_rd;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [PTR_W-1:0]      r_rr_ptr;

    logic [2*NUM_REQ-1:0]  w_dbl;
    logic [NUM_REQ-1:0]    w_rot;
    logic                  w_any;
    logic [PTR_W-1:0]      w_off;
    logic [PTR_W:0]        w_sum;
    logic [PTR_W:0]        w_sum_wrap;
    logic [PTR_W-1:0]      w_win;
    logic [4:0]            w_win_rd;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [ID_WIDTH-1:0]   w_win_id;
    logic                  w_fire;
    logic                  w_can_accept;
    logic                  w_grant;
    logic                  w_bypass;
    logic [4:0]            w_rd_sel;

    assign w_fire       = r_out_valid & ~wb_port_busy_i;
    assign w_can_accept = ~r_out_valid | w_fire;

    // Rotate the request vector so bit k is the unit k steps after rr_ptr.
    assign w_dbl = {req_valid_i, req_valid_i};
    assign w_rot = NUM_REQ'(w_dbl >> r_rr_ptr);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = PTR_W'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sum_wrap = w_sum - L_NUM;
    assign w_win      = (w_sum >= L_NUM) ? w_sum_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];

    always_comb begin
        w_win_rd   = '0;
        w_win_data = '0;
        w_win_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_win_rd   = req_rd_addr_i[5*i +: 5];
                w_win_data = req_data_i[DATA_WIDTH*i +: DATA_WIDTH];
                w_win_id   = req_id_i[ID_WIDTH*i +: ID_WIDTH];
            end
        end
    end

    // Gating with rst_n keeps ready and any bypassed commit quiet during reset.
    assign w_grant = w_any & w_can_accept & rst_n;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = w_grant & (w_win == PTR_W'(i));
        end
    end

`ifdef LONG_WB_BYPASS_EN
    assign w_bypass = w_grant & ~r_out_valid & ~wb_port_busy_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_rd_sel       = w_bypass ? w_win_rd : r_out_rd;
    assign commit_valid_o = w_fire | w_bypass;
    assign commit_id_o    = w_bypass ? w_win_id : r_out_id;
    assign reg_we_o       = commit_valid_o & (w_rd_sel != 5'd0);
    assign reg_waddr_o    = w_rd_sel;
    assign reg_wdata_o    = w_bypass ? w_win_data : r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_rd    <= '0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_grant && !w_bypass) begin
                r_out_valid <= 1'b1;
                r_out_rd    <= w_win_rd;
                r_out_data  <= w_win_data;
                r_out_id    <= w_win_id;
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_grant) begin
                r_rr_ptr <= (w_win == L_LAST) ? '0 : w_win + 1'b1;
            end
        end
    end

endmodule
